// File: rtl/fpm_pkg.sv
// Shared constants, entry type and IEEE-754 classification helpers for the FPM result stage.
package fpm_pkg;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    localparam int NV = 3;
    localparam int OF = 2;
    localparam int UF = 1;
    localparam int ZR = 0;

    typedef struct packed {
        logic [31:0] m;
        logic [3:0]  flags;
    } fpm_entry_t;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == EXP_MAX) && (x[22:0] != 23'h0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == EXP_MAX) && (x[22:0] == 23'h0);
    endfunction

    // Denormals are flushed, so any zero exponent counts as zero.
    function automatic logic is_zero(input logic [31:0] x);
        return x[30:23] == 8'h00;
    endfunction

endpackage

// File: rtl/fpm_result_stage_if.sv
// Valid/ready bundle carrying FPM results into the stage and fixed-up products out of it.
interface fpm_result_stage_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] in_m;
    logic        in_underflow;
    logic        in_overflow;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_m;
    logic [3:0]  out_flags;

    modport master (
        output in_valid, in_a, in_b, in_m, in_underflow, in_overflow, out_ready,
        input  in_ready, out_valid, out_m, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_m, in_underflow, in_overflow, out_ready,
        output in_ready, out_valid, out_m, out_flags
    );

endinterface

// File: rtl/fpm_result_fifo.sv
// DEPTH x WIDTH first-word-fall-through FIFO with occupancy count; head reads as zero when empty.
module fpm_result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 36,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      count_reg, count_next;
    logic             do_wr, do_rd;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // DEPTH is a power of two, so plain increment wraps the pointers.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_wr) wr_ptr_next = wr_ptr_reg + 1'b1;
        if (do_rd) rd_ptr_next = rd_ptr_reg + 1'b1;
        if (do_wr && !do_rd)      count_next = count_reg + 1'b1;
        else if (do_rd && !do_wr) count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_reg[wr_ptr_reg] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/fpm_result_stage.sv
// Fixes up IEEE-754 special cases on FPM products, buffers them and keeps sticky flags.
// Optional event counters of_cnt/uf_cnt are built when FPM_EVENT_CNT_EN is defined.
module fpm_result_stage
    import fpm_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fpm_result_stage_if.slave  bus,
    input  logic               flag_clr,
    output logic [3:0]         sticky_flags
`ifdef FPM_EVENT_CNT_EN
   ,output logic [CNT_W-1:0]   of_cnt,
    output logic [CNT_W-1:0]   uf_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic        sign;
    logic [31:0] fix_m;
    logic [3:0]  fix_flags;
    logic        accept;
    logic        fifo_full, fifo_empty;
    logic [AW:0] fifo_count;
    fpm_entry_t  wr_entry, head;
    logic [3:0]  sticky_reg, sticky_next;

    assign sign = bus.in_a[31] ^ bus.in_b[31];

    // Priority order matters: NaN/0*inf beats inf, which beats zero, before FPM flags.
    always_comb begin
        fix_m     = bus.in_m;
        fix_flags = 4'b0000;
        if (is_nan(bus.in_a) || is_nan(bus.in_b) ||
            (is_zero(bus.in_a) && is_inf(bus.in_b)) ||
            (is_inf(bus.in_a) && is_zero(bus.in_b))) begin
            fix_m         = QNAN;
            fix_flags[NV] = 1'b1;
        end else if (is_inf(bus.in_a) || is_inf(bus.in_b)) begin
            fix_m = {sign, EXP_MAX, 23'h0};
        end else if (is_zero(bus.in_a) || is_zero(bus.in_b)) begin
            fix_m         = {sign, 31'h0};
            fix_flags[ZR] = 1'b1;
        end else if (bus.in_overflow || (bus.in_m[30:23] == EXP_MAX)) begin
            fix_m         = {sign, EXP_MAX, 23'h0};
            fix_flags[OF] = 1'b1;
        end else if (bus.in_underflow) begin
            fix_m         = {sign, 31'h0};
            fix_flags[UF] = 1'b1;
            fix_flags[ZR] = 1'b1;
        end
    end

    assign wr_entry.m     = fix_m;
    assign wr_entry.flags = fix_flags;

    assign bus.in_ready = !fifo_full;
    assign accept       = bus.in_valid && !fifo_full;

    fpm_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fpm_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_data (wr_entry),
        .rd_en   (bus.out_ready),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.out_valid = (fifo_count != '0) && !fifo_empty;
    assign bus.out_m     = head.m;
    assign bus.out_flags = head.flags;

    // A clear coinciding with an accepted entry keeps only that entry's flags.
    always_comb begin
        sticky_next = sticky_reg;
        if (flag_clr)    sticky_next = accept ? fix_flags : 4'b0000;
        else if (accept) sticky_next = sticky_reg | fix_flags;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_reg <= 4'b0000;
        else        sticky_reg <= sticky_next;
    end

    assign sticky_flags = sticky_reg;

`ifdef FPM_EVENT_CNT_EN
    logic [CNT_W-1:0] cnt_reg [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_evt_cnt
            localparam int FLAG_BIT = (gi == 0) ? OF : UF;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt_reg[gi] <= '0;
                else if (flag_clr)
                    cnt_reg[gi] <= '0;
                else if (accept && fix_flags[FLAG_BIT] && (cnt_reg[gi] != '1))
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
        end
    endgenerate

    assign of_cnt = cnt_reg[0];
    assign uf_cnt = cnt_reg[1];
`endif

endmodule

// File: tb/tb_fpm_result_stage.sv
// Directed bench for fpm_result_stage: fixup rules, FIFO backpressure, sticky flags, reset.
module tb_fpm_result_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flag_clr;
    logic [3:0] sticky_flags;
`ifdef FPM_EVENT_CNT_EN
    logic [15:0] of_cnt, uf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fpm_result_stage_if bus ();

    fpm_result_stage #(.DEPTH(2), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .flag_clr     (flag_clr),
        .sticky_flags (sticky_flags)
`ifdef FPM_EVENT_CNT_EN
       ,.of_cnt       (of_cnt),
        .uf_cnt       (uf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] m,
                         input logic uf, input logic of);
        bus.in_valid     = 1'b1;
        bus.in_a         = a;
        bus.in_b         = b;
        bus.in_m         = m;
        bus.in_underflow = uf;
        bus.in_overflow  = of;
    endtask

    // Push one entry with out_ready low, then report the new head.
    task automatic push_check(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] m, input logic uf, input logic of,
                              input logic [31:0] exp_m, input logic [3:0] exp_f);
        drive(a, b, m, uf, of);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_m !== exp_m || bus.out_flags !== exp_f) begin
            errors++;
            $display("FAIL %s: valid=%b m=%h flags=%b, expected valid=1 m=%h flags=%b",
                     name, bus.out_valid, bus.out_m, bus.out_flags, exp_m, exp_f);
        end else
            $display("ok   %s: m=%h flags=%b", name, bus.out_m, bus.out_flags);
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_m !== 32'h0 || bus.out_flags !== 4'h0 ||
            sticky_flags !== 4'h0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: valid=%b m=%h flags=%b sticky=%b ready=%b, expected 0 0 0 0 1",
                     bus.out_valid, bus.out_m, bus.out_flags, sticky_flags, bus.in_ready);
        end else
            $display("ok   reset state");
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_normal();
        push_check("normal", 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 1'b0, 1'b0,
                   32'h40C0_0000, 4'b0000);
        pop_one();
        checks++;
        if (bus.out_valid !== 1'b0 || sticky_flags !== 4'b0000) begin
            errors++;
            $display("FAIL normal_pop: valid=%b sticky=%b, expected 0 0000", bus.out_valid, sticky_flags);
        end else
            $display("ok   normal_pop");
    endtask

    task automatic test_overflow();
        push_check("ovf_pos", 32'h7F00_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b1,
                   32'h7F80_0000, 4'b0100);
        checks++;
        if (sticky_flags !== 4'b0100) begin
            errors++;
            $display("FAIL ovf_sticky: sticky=%b, expected 0100", sticky_flags);
        end else
            $display("ok   ovf_sticky");
        pop_one();
        push_check("ovf_neg", 32'hFF00_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b1,
                   32'hFF80_0000, 4'b0100);
        pop_one();
        push_check("exp_sat", 32'h4000_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0, 1'b0,
                   32'h7F80_0000, 4'b0100);
        pop_one();
    endtask

    task automatic test_special();
        push_check("zero_x_inf", 32'h0000_0000, 32'h7F80_0000, 32'h1234_5678, 1'b0, 1'b0,
                   32'h7FC0_0000, 4'b1000);
        pop_one();
        push_check("negzero", 32'h8000_0000, 32'h3F80_0000, 32'h1234_5678, 1'b0, 1'b0,
                   32'h8000_0000, 4'b0001);
        pop_one();
        push_check("nan_op", 32'h3F80_0000, 32'h7F80_0001, 32'h1234_5678, 1'b1, 1'b1,
                   32'h7FC0_0000, 4'b1000);
        pop_one();
        push_check("inf_x_norm", 32'hFF80_0000, 32'h4000_0000, 32'h1234_5678, 1'b0, 1'b1,
                   32'hFF80_0000, 4'b0000);
        pop_one();
        checks++;
        if (sticky_flags !== 4'b1101) begin
            errors++;
            $display("FAIL special_sticky: sticky=%b, expected 1101", sticky_flags);
        end else
            $display("ok   special_sticky");
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0);
        step();
        drive(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
        step();
        drive(32'h3F80_0000, 32'h4040_0000, 32'h4040_0000, 1'b0, 1'b0);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_m !== 32'h3F80_0000) begin
            errors++;
            $display("FAIL bp_full: ready=%b head=%h, expected 0 3f800000", bus.in_ready, bus.out_m);
        end else
            $display("ok   bp_full");
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_m !== 32'h3F80_0000 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: valid=%b head=%h ready=%b, expected 1 3f800000 0",
                     bus.out_valid, bus.out_m, bus.in_ready);
        end else
            $display("ok   bp_stall");
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_bypass: ready=%b, expected 0", bus.in_ready);
        end else
            $display("ok   bp_no_bypass");
        step();
        checks++;
        if (bus.out_m !== 32'h4000_0000 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_pop1: head=%h ready=%b, expected 40000000 1", bus.out_m, bus.in_ready);
        end else
            $display("ok   bp_pop1");
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_m !== 32'h4040_0000 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_pushpop: valid=%b head=%h ready=%b, expected 1 40400000 1",
                     bus.out_valid, bus.out_m, bus.in_ready);
        end else
            $display("ok   bp_pushpop");
        step();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: valid=%b, expected 0", bus.out_valid);
        end else
            $display("ok   bp_drain");
    endtask

    task automatic test_flag_clr();
`ifdef FPM_EVENT_CNT_EN
        checks++;
        if (of_cnt !== 16'd3 || uf_cnt !== 16'd0) begin
            errors++;
            $display("FAIL cnt_before: of=%0d uf=%0d, expected 3 0", of_cnt, uf_cnt);
        end else
            $display("ok   cnt_before");
`endif
        drive(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b1, 1'b0);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (sticky_flags !== 4'b0011 || bus.out_m !== 32'h0000_0000 || bus.out_flags !== 4'b0011) begin
            errors++;
            $display("FAIL clr_with_uf: sticky=%b m=%h flags=%b, expected 0011 00000000 0011",
                     sticky_flags, bus.out_m, bus.out_flags);
        end else
            $display("ok   clr_with_uf");
`ifdef FPM_EVENT_CNT_EN
        checks++;
        if (of_cnt !== 16'd0 || uf_cnt !== 16'd0) begin
            errors++;
            $display("FAIL cnt_clr: of=%0d uf=%0d, expected 0 0", of_cnt, uf_cnt);
        end else
            $display("ok   cnt_clr");
`endif
        pop_one();
        push_check("uf_neg", 32'h8080_0000, 32'h0080_0000, 32'h0000_0000, 1'b1, 1'b0,
                   32'h8000_0000, 4'b0011);
`ifdef FPM_EVENT_CNT_EN
        checks++;
        if (uf_cnt !== 16'd1) begin
            errors++;
            $display("FAIL cnt_uf_inc: uf=%0d, expected 1", uf_cnt);
        end else
            $display("ok   cnt_uf_inc");
`endif
        pop_one();
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        checks++;
        if (sticky_flags !== 4'b0000) begin
            errors++;
            $display("FAIL clr_only: sticky=%b, expected 0000", sticky_flags);
        end else
            $display("ok   clr_only");
    endtask

    task automatic test_reset_mid();
        drive(32'h7F00_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b1);
        step();
        drive(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || sticky_flags !== 4'b0100) begin
            errors++;
            $display("FAIL mid_full: valid=%b ready=%b sticky=%b, expected 1 0 0100",
                     bus.out_valid, bus.in_ready, sticky_flags);
        end else
            $display("ok   mid_full");
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || sticky_flags !== 4'b0000 || bus.out_m !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b sticky=%b m=%h, expected 0 0000 00000000",
                     bus.out_valid, sticky_flags, bus.out_m);
        end else
            $display("ok   mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: ready=%b valid=%b, expected 1 0", bus.in_ready, bus.out_valid);
        end else
            $display("ok   post_reset");
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_a         = 32'h0;
        bus.in_b         = 32'h0;
        bus.in_m         = 32'h0;
        bus.in_underflow = 1'b0;
        bus.in_overflow  = 1'b0;
        bus.out_ready    = 1'b0;
        flag_clr         = 1'b0;
        test_reset();
        test_normal();
        test_overflow();
        test_special();
        test_backpressure();
        test_flag_clr();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpm_result_stage.md
Name: fpm_result_stage

Overview:
- Downstream consumer of the combinational single-precision multiplier FPM.
- Registers each product with its operands and underflow/overflow.
- Fixes up IEEE-754 special cases the multiplier does not handle: zero, infinity, NaN, and an exponent that saturates to all-ones.
- Buffers results in a small FIFO with valid/ready on both sides, and keeps sticky exception flags for software.

Parameters:
- DEPTH, 2: FIFO entries; power of two, at least 2.
- CNT_W, 16: width of the optional event counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  FPM result and operands valid.
- in_ready  out  1  stage can accept this cycle.
- in_a  in  32  operand A given to FPM.
- in_b  in  32  operand B given to FPM.
- in_m  in  32  FPM product M.
- in_underflow  in  1  FPM underflow.
- in_overflow  in  1  FPM overflow.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head.
- out_m  out  32  fixed-up product.
- out_flags  out  4  {nv, of, uf, zr} for the head entry.
- sticky_flags  out  4  OR of the flags of all accepted entries since reset or clear.
- flag_clr  in  1  clears sticky_flags.
- of_cnt  out  CNT_W  overflow count; present only with FPM_EVENT_CNT_EN.
- uf_cnt  out  CNT_W  underflow count; present only with FPM_EVENT_CNT_EN.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, so out_valid=0. out_m=0, out_flags=0, sticky_flags=0, counters=0. in_ready=1 after reset releases.
- Reset mid-operation discards all buffered entries.
- Handshake: transfer occurs when valid and ready are both high at a rising edge. in_ready = (count != DEPTH).
- When full, in_ready stays low even if out_ready is high; there is no same-cycle bypass.
- Push and pop in the same cycle when not full leave count unchanged.
- Latency: an entry accepted at edge k shows out_valid=1 from edge k onward (one-cycle visibility) if the FIFO was empty.
- out_m and out_flags are stable while out_valid=1 and out_ready=0.
- Order is strictly FIFO. Pointers wrap modulo DEPTH.
- Fixup is combinational before the FIFO write. The first matching rule applies; s = in_a[31]^in_b[31].
  1. Either operand is NaN (exp=FF, mant!=0), or zero times infinity: out_m=32'h7FC00000, nv=1.
  2. Either operand is infinity: out_m={s,8'hFF,23'h0}.
  3. Either operand has exp=00 (denormals treated as zero): out_m={s,31'h0}, zr=1.
  4. in_overflow=1, or in_m[30:23]==8'hFF: out_m={s,8'hFF,23'h0}, of=1.
  5. in_underflow=1: out_m={s,31'h0}, uf=1, zr=1.
  6. Otherwise out_m=in_m with all flags 0.
- Sticky flags: on an accepted entry, sticky_flags |= flags.
- flag_clr takes effect at the next edge. If flag_clr coincides with an accepted flag, the new flag wins: result is the new flags only.
- No state machine beyond the FIFO pointers and count.

Optional Feature:
- Macro FPM_EVENT_CNT_EN.
- Defined:
  - of_cnt and uf_cnt exist.
  - Each increments by 1 on every accepted entry with of or uf set.
  - Counters saturate at all-ones and are cleared by flag_clr. Clear wins over increment.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package fpm_pkg:
  - Constants: QNAN=32'h7FC00000, EXP_MAX=8'hFF.
  - Flag bit indices NV=3, OF=2, UF=1, ZR=0.
  - A typedef for the entry: {m[31:0], flags[3:0]}.
  - Functions is_nan, is_inf, is_zero.
- One sub-module, fpm_result_fifo: a parameterised DEPTH x 36 synchronous FIFO with count.
- The fixup logic stays inline in the top module.

Test Plan:
- Normal path: A=0x40400000, B=0x40000000, M=0x40C00000, no FPM flags -> out_m=0x40C00000, out_flags=0, out_valid the cycle after acceptance.
- Overflow: A=B=0x7F000000 with in_overflow=1 -> out_m=0x7F800000, of=1, sticky_flags=4'b0100. Repeat with A=0xFF000000 -> out_m=0xFF800000.
- Special operands: A=0x00000000, B=0x7F800000 -> 0x7FC00000 with nv=1. A=0x80000000, B=0x3F800000 -> 0x80000000 with zr=1.
- Backpressure: hold out_ready=0 and push 3 items -> in_ready drops after 2. Release out_ready -> items pop in order with stable data while stalled.
- flag_clr in the same cycle as an accepted underflow entry -> sticky_flags=4'b0011 at the next edge. With FPM_EVENT_CNT_EN defined, uf_cnt=0.
- Assert rst_n low with 2 entries buffered -> out_valid=0 and sticky_flags=0 immediately. After release, in_ready=1.
